// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start + DATA_W data bits (LSB first) + parity + stop.
// Recomputes XOR parity and reports the word with valid / parity / framing pulses.
module xor_parity_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              run, run_n;
    logic              perr, perr_n;
    logic [DATA_W-1:0] data_out_n;
    logic              data_valid_n;
    logic              parity_err_n;
    logic              frame_err_n;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            run        <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            run        <= run_n;
            perr       <= perr_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state logic; everything holds except the pulses when no strobe arrives
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shift_n      = shift;
        run_n        = run;
        perr_n       = perr;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;

        if (rx_en) begin
            case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        run_n   = 1'b0;
                    end
                end
                DATA: begin
                    shift_n[IDX_W'(cnt)] = rx_bit;
                    run_n                = run ^ rx_bit;
                    cnt_n                = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    perr_n  = ((run ^ rx_bit) != PARITY_ODD);
                    state_n = STOP;
                end
                STOP: begin
                    if (rx_bit) begin
                        data_out_n   = shift;
                        data_valid_n = 1'b1;
                        parity_err_n = perr;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Bench for xor_parity_rx: directed frame table, reset / back-to-back sequences,
// and randomized frames checked against a frame-level reference model.
module tb_xor_parity_rx;

    logic       clk;
    logic       rst;
    logic       rx_en;
    logic       rx_bit;
    logic [7:0] dout_e, dout_o;
    logic       valid_e, valid_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;

    int checks = 0;
    int errors = 0;

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_bit(rx_bit),
        .data_out(dout_e), .data_valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_bit(rx_bit),
        .data_out(dout_o), .data_valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        int         period;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bit strobe: period-1 disabled cycles with line noise, then one enabled cycle
    task automatic strobe(input logic b, input int period);
        repeat (period - 1) begin
            rx_en  = 1'b0;
            rx_bit = 1'($urandom);
            @(negedge clk);
        end
        rx_en  = 1'b1;
        rx_bit = b;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int period);
        strobe(1'b0, period);
        chk("busy_after_start", 32'(busy_e), 32'd1);
        for (int i = 0; i < 8; i++) strobe(d[i], period);
        strobe(p, period);
        chk("no_pulse_before_stop", 32'({valid_e, ferr_e}), 32'd0);
        strobe(s, period);
        chk("busy_after_stop", 32'(busy_e), 32'd0);
    endtask

    // Frame-level reference: parity from a population count over data and parity bit
    function automatic logic model_perr(input logic [7:0] d, input logic p, input logic odd);
        int ones;
        ones = $countones({d, p});
        return ((ones % 2) == 1) != odd;
    endfunction

    initial begin
        logic [7:0] m_dout_e;
        logic [7:0] m_dout_o;
        logic [7:0] d;
        logic       p;
        logic       s;
        int         per;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 4, 8'h3C, 1'b0, 1'b0};

        rst    = 1'b1;
        rx_en  = 1'b0;
        rx_bit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_dout", 32'(dout_e), 32'd0);
        chk("reset_pulses", 32'({valid_e, perr_e, ferr_e}), 32'd0);
        chk("reset_busy", 32'(busy_e), 32'd0);
        rst = 1'b0;
        strobe(1'b1, 1);
        chk("idle_line_high", 32'(busy_e), 32'd0);

        // Directed frames on the even-parity receiver
        for (int k = 0; k < 4; k++) begin
            send_frame(tbl[k].data, tbl[k].pbit, tbl[k].stop, tbl[k].period);
            chk($sformatf("vec%0d_dout", k), 32'(dout_e), 32'(tbl[k].exp_dout));
            chk($sformatf("vec%0d_valid", k), 32'(valid_e), 32'(tbl[k].stop));
            chk($sformatf("vec%0d_perr", k), 32'(perr_e), 32'(tbl[k].exp_perr));
            chk($sformatf("vec%0d_ferr", k), 32'(ferr_e), 32'(tbl[k].exp_ferr));
            strobe(1'b1, 1);
            chk($sformatf("vec%0d_pulse_clear", k), 32'({valid_e, perr_e, ferr_e}), 32'd0);
        end

        // Reset in the middle of a frame of all-ones data
        strobe(1'b0, 1);
        repeat (3) strobe(1'b1, 1);
        chk("abort_busy_before_rst", 32'(busy_e), 32'd1);
        rst    = 1'b1;
        rx_en  = 1'b1;
        rx_bit = 1'b1;
        @(negedge clk);
        chk("abort_rst_dout", 32'({dout_e, dout_o}), 32'd0);
        chk("abort_rst_pulses", 32'({valid_e, perr_e, ferr_e, valid_o, ferr_o}), 32'd0);
        chk("abort_rst_busy", 32'({busy_e, busy_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        chk("after_rst_dout", 32'(dout_e), 32'h5A);
        chk("after_rst_valid", 32'(valid_e), 32'd1);
        chk("after_rst_perr", 32'(perr_e), 32'd0);

        // Odd parity, back-to-back frames
        send_frame(8'h01, 1'b0, 1'b1, 1);
        chk("odd1_valid", 32'(valid_o), 32'd1);
        chk("odd1_perr", 32'(perr_o), 32'd0);
        chk("odd1_dout", 32'(dout_o), 32'h01);
        send_frame(8'h01, 1'b1, 1'b1, 1);
        chk("odd2_valid", 32'(valid_o), 32'd1);
        chk("odd2_perr", 32'(perr_o), 32'd1);
        chk("odd2_dout", 32'(dout_o), 32'h01);
        repeat (4) strobe(1'b1, 1);
        chk("odd_idle_busy", 32'({busy_o, busy_e}), 32'd0);
        chk("odd_idle_pulses", 32'({valid_o, perr_o, ferr_o}), 32'd0);

        // Randomized frames against the reference model on both receivers
        m_dout_e = 8'h01;
        m_dout_o = 8'h01;
        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 4) != 0);
            per = $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) strobe(1'b1, $urandom_range(1, 2));
            send_frame(d, p, s, per);
            if (s) begin
                m_dout_e = d;
                m_dout_o = d;
            end
            chk($sformatf("rnd%0d_dout_e", n), 32'(dout_e), 32'(m_dout_e));
            chk($sformatf("rnd%0d_dout_o", n), 32'(dout_o), 32'(m_dout_o));
            chk($sformatf("rnd%0d_valid", n), 32'({valid_e, valid_o}), s ? 32'd3 : 32'd0);
            chk($sformatf("rnd%0d_ferr", n), 32'({ferr_e, ferr_o}), s ? 32'd0 : 32'd3);
            chk($sformatf("rnd%0d_perr_e", n), 32'(perr_e), 32'(s && model_perr(d, p, 1'b0)));
            chk($sformatf("rnd%0d_perr_o", n), 32'(perr_o), 32'(s && model_perr(d, p, 1'b1)));
            strobe(1'b1, 1);
            chk($sformatf("rnd%0d_clear", n), 32'({valid_e, valid_o, ferr_e, ferr_o}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
